// File: rtl/rf_writeback_sequencer.sv
// rf_writeback_sequencer
// Buffers tagged execution results, issues one register-file write per cycle,
// tracks which write names hold data, and frees names strictly in allocation
// order once each is both written and retired.
module rf_writeback_sequencer #(
    parameter int name_width = 1,
    parameter int data_width = 1,
    parameter int fifo_depth = 2
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  IN_VALID,
    input  logic [name_width-1:0] IN_NAME,
    input  logic [data_width-1:0] IN_DATA,
    output logic                  IN_READY,
    output logic                  WE,
    output logic [name_width-1:0] NAME_W,
    output logic [data_width-1:0] D_W,
    input  logic                  RETIRE_E,
    output logic                  RETIRE_READY,
    output logic                  WFE,
    output logic [name_width-1:0] W_F,
    input  logic                  F_READY,
    output logic                  DUP_ERR
);

    localparam int num_names    = 2 ** name_width;
    localparam int ptr_width    = (fifo_depth > 1) ? $clog2(fifo_depth) : 1;
    localparam int cnt_width    = $clog2(fifo_depth) + 1;
    localparam int credit_width = name_width + 1;

    // Result FIFO storage and bookkeeping
    logic [name_width-1:0]   name_mem [fifo_depth];
    logic [data_width-1:0]   data_mem [fifo_depth];
    logic [ptr_width-1:0]    rd_ptr_reg;
    logic [ptr_width-1:0]    wr_ptr_reg;
    logic [cnt_width-1:0]    count_reg;
    logic [cnt_width-1:0]    count_next;

    // Name tracking and free sequencing
    logic [num_names-1:0]    written_reg;
    logic [credit_width-1:0] credits_reg;
    logic [credit_width-1:0] credits_next;
    logic [name_width-1:0]   fp_reg;
    logic                    dup_err_reg;

    logic push;
    logic pop;
    logic retire_accept;
    logic free_fire;
    logic dup_hit;

    // Handshake and output decode; everything but FIFO data comes from registered state
    always_comb begin
        IN_READY      = (count_reg < cnt_width'(fifo_depth));
        WE            = (count_reg != '0);
        NAME_W        = WE ? name_mem[rd_ptr_reg] : '0;
        D_W           = WE ? data_mem[rd_ptr_reg] : '0;
        RETIRE_READY  = (credits_reg < credit_width'(num_names));
        WFE           = written_reg[fp_reg] && (credits_reg != '0);
        W_F           = fp_reg;
        DUP_ERR       = dup_err_reg;
        push          = IN_VALID && IN_READY;
        pop           = WE;
        retire_accept = RETIRE_E && RETIRE_READY;
        free_fire     = WFE && F_READY;
        dup_hit       = WE && written_reg[NAME_W];
    end

    // FIFO occupancy: a simultaneous push and pop leaves it unchanged
    always_comb begin
        count_next = count_reg;
        case ({push, pop})
            2'b10:   count_next = count_reg + cnt_width'(1);
            2'b01:   count_next = count_reg - cnt_width'(1);
            default: count_next = count_reg;
        endcase
    end

    // Retire credits: a fire and an accepted retire in the same cycle cancel
    always_comb begin
        credits_next = credits_reg;
        case ({retire_accept, free_fire})
            2'b10:   credits_next = credits_reg + credit_width'(1);
            2'b01:   credits_next = credits_reg - credit_width'(1);
            default: credits_next = credits_reg;
        endcase
    end

    // FIFO payload array; contents need no reset because outputs are masked when empty
    always_ff @(posedge CLK) begin
        if (push) begin
            name_mem[wr_ptr_reg] <= IN_NAME;
            data_mem[wr_ptr_reg] <= IN_DATA;
        end
    end

    // FIFO pointers and count; power-of-two depth lets pointers wrap naturally
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) wr_ptr_reg <= wr_ptr_reg + ptr_width'(1);
            if (pop)  rd_ptr_reg <= rd_ptr_reg + ptr_width'(1);
            count_reg <= count_next;
        end
    end

    // Per-name written flags; a new write wins over a free of the same name
    generate
        for (genvar gi = 0; gi < num_names; gi++) begin : g_written
            always_ff @(posedge CLK or negedge RST) begin
                if (!RST) begin
                    written_reg[gi] <= 1'b0;
                end else if (WE && (NAME_W == name_width'(gi))) begin
                    written_reg[gi] <= 1'b1;
                end else if (free_fire && (fp_reg == name_width'(gi))) begin
                    written_reg[gi] <= 1'b0;
                end
            end
        end
    endgenerate

    // Credits, in-order free pointer and the sticky duplicate-write flag
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            credits_reg <= '0;
            fp_reg      <= '0;
            dup_err_reg <= 1'b0;
        end else begin
            credits_reg <= credits_next;
            if (free_fire) fp_reg <= fp_reg + name_width'(1);
            if (dup_hit)   dup_err_reg <= 1'b1;
        end
    end

endmodule

// File: tb/tb_rf_writeback_sequencer.sv
// Randomized and directed bench for rf_writeback_sequencer against a
// queue/array reference model of the writeback, credit and free rules.
module tb_rf_writeback_sequencer;

    localparam int NW  = 2;
    localparam int DW  = 8;
    localparam int FD  = 2;
    localparam int NUM = 2 ** NW;

    logic          CLK = 1'b0;
    logic          RST = 1'b0;
    logic          IN_VALID = 1'b0;
    logic [NW-1:0] IN_NAME = '0;
    logic [DW-1:0] IN_DATA = '0;
    logic          IN_READY;
    logic          WE;
    logic [NW-1:0] NAME_W;
    logic [DW-1:0] D_W;
    logic          RETIRE_E = 1'b0;
    logic          RETIRE_READY;
    logic          WFE;
    logic [NW-1:0] W_F;
    logic          F_READY = 1'b0;
    logic          DUP_ERR;

    rf_writeback_sequencer #(
        .name_width(NW),
        .data_width(DW),
        .fifo_depth(FD)
    ) dut (
        .CLK(CLK),
        .RST(RST),
        .IN_VALID(IN_VALID),
        .IN_NAME(IN_NAME),
        .IN_DATA(IN_DATA),
        .IN_READY(IN_READY),
        .WE(WE),
        .NAME_W(NAME_W),
        .D_W(D_W),
        .RETIRE_E(RETIRE_E),
        .RETIRE_READY(RETIRE_READY),
        .WFE(WFE),
        .W_F(W_F),
        .F_READY(F_READY),
        .DUP_ERR(DUP_ERR)
    );

    always #5 CLK = ~CLK;

    // Reference model state
    typedef struct packed {
        logic [NW-1:0] name;
        logic [DW-1:0] data;
    } res_t;

    res_t fifo_q[$];
    bit   wr_m [NUM];
    int   cred_m;
    int   fp_m;
    bit   dup_m;

    int checks = 0;
    int errors = 0;
    int cycle  = 0;
    int alloc  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", tag, cycle, obs, exp);
        end
    endtask

    task automatic model_reset();
        fifo_q.delete();
        for (int i = 0; i < NUM; i++) wr_m[i] = 1'b0;
        cred_m = 0;
        fp_m   = 0;
        dup_m  = 1'b0;
    endtask

    task automatic check_outputs();
        logic [31:0] e_name;
        logic [31:0] e_data;
        e_name = (fifo_q.size() != 0) ? 32'(fifo_q[0].name) : 32'd0;
        e_data = (fifo_q.size() != 0) ? 32'(fifo_q[0].data) : 32'd0;
        chk("in_ready", 32'(IN_READY), 32'(fifo_q.size() < FD));
        chk("we", 32'(WE), 32'(fifo_q.size() != 0));
        chk("name_w", 32'(NAME_W), e_name);
        chk("d_w", 32'(D_W), e_data);
        chk("retire_ready", 32'(RETIRE_READY), 32'(cred_m < NUM));
        chk("wfe", 32'(WFE), 32'(wr_m[fp_m] && cred_m != 0));
        chk("w_f", 32'(W_F), 32'(fp_m));
        chk("dup_err", 32'(DUP_ERR), 32'(dup_m));
    endtask

    // Advance the model by one clock using the inputs currently applied
    task automatic model_update();
        res_t head;
        bit we_m, push_m, acc_m, fire_m;
        we_m   = (fifo_q.size() != 0);
        push_m = IN_VALID && (fifo_q.size() < FD);
        acc_m  = RETIRE_E && (cred_m < NUM);
        fire_m = wr_m[fp_m] && (cred_m != 0) && F_READY;
        head   = '0;
        if (we_m) begin
            head = fifo_q.pop_front();
            if (wr_m[head.name]) dup_m = 1'b1;
        end
        if (fire_m) begin
            wr_m[fp_m] = 1'b0;
            fp_m = (fp_m + 1) % NUM;
        end
        if (we_m) wr_m[head.name] = 1'b1;
        cred_m = cred_m + int'(acc_m) - int'(fire_m);
        if (push_m) begin
            head.name = IN_NAME;
            head.data = IN_DATA;
            fifo_q.push_back(head);
        end
    endtask

    // One cycle: drive at the falling edge, check just after, then model the rising edge
    task automatic step(input logic v, input logic [NW-1:0] n, input logic [DW-1:0] d,
                        input logic r, input logic f);
        @(negedge CLK);
        IN_VALID = v;
        IN_NAME  = n;
        IN_DATA  = d;
        RETIRE_E = r;
        F_READY  = f;
        #1;
        cycle++;
        check_outputs();
        model_update();
    endtask

    // Asynchronous reset asserted between edges; outputs must clear immediately
    task automatic do_reset();
        @(negedge CLK);
        #2;
        RST      = 1'b0;
        IN_VALID = 1'b0;
        RETIRE_E = 1'b0;
        F_READY  = 1'b0;
        #1;
        model_reset();
        check_outputs();
        @(negedge CLK);
        @(negedge CLK);
        RST = 1'b1;
    endtask

    initial begin
        model_reset();
        do_reset();

        // Idle after reset
        repeat (3) step(0, 0, 0, 0, 0);

        // Single result: write in cycle 1, retire, free of name 0, fp advances
        step(1, 0, 8'h05, 0, 0);
        step(0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0);
        chk("single_fp", 32'(W_F), 32'd1);

        // Out-of-order writes: names 2 after 1 are allocated next; write 2 before 1
        step(1, 2, 8'hA2, 1, 1);
        step(1, 1, 8'hA1, 1, 1);
        repeat (4) step(0, 0, 0, 0, 1);

        // Backpressure then wrap: name 3 and 0 written and retired, free held off
        step(1, 3, 8'h33, 1, 0);
        step(1, 0, 8'h40, 1, 0);
        repeat (3) step(0, 0, 0, 0, 0);
        chk("bp_wfe", 32'(WFE), 32'd1);
        repeat (3) step(0, 0, 0, 0, 1);
        chk("wrap_fp", 32'(W_F), 32'd1);

        // Mid-run reset with results queued and a credit held
        step(1, 1, 8'h11, 1, 0);
        step(1, 2, 8'h22, 0, 0);
        do_reset();
        step(0, 0, 0, 0, 0);

        // Credit saturation and duplicate write detection
        repeat (NUM + 1) step(0, 0, 0, 1, 0);
        chk("sat_retire_ready", 32'(RETIRE_READY), 32'd0);
        step(1, 2, 8'h21, 0, 0);
        step(1, 2, 8'h22, 0, 0);
        repeat (3) step(0, 0, 0, 0, 0);
        chk("dup_sticky", 32'(DUP_ERR), 32'd1);
        do_reset();

        // Random names: exercises duplicates and arbitrary interleavings
        for (int i = 0; i < 300; i++)
            step(1'($urandom_range(0, 1)), NW'($urandom), DW'($urandom),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0));
        do_reset();

        // Allocation-ordered names with random pacing and backpressure
        alloc = 0;
        for (int i = 0; i < 400; i++) begin
            logic v;
            v = ($urandom_range(0, 2) != 0);
            step(v, NW'(alloc), DW'($urandom), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 3) != 0));
            if (v) alloc = (alloc + 1) % NUM;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
